digit_pulse_gen: RTL and testbench

Master digit-timing source for the control section. Produces the digit pulses d0, d1, d18 and d35, the odd/even minor-cycle indication and the major-cycle markers that the timing-pulse consumers (CCU 1 and the others) decode. A digit counter is nested inside a minor-cycle counter, and a run/stop/step controller gates both counters. Stops only on minor-cycle boundaries.

---
 rtl/edsac_timing_pkg.sv | 18 +
 rtl/digit_pulse_gen_if.sv | 58 +++++
 rtl/mod_counter.sv | 36 +++
 rtl/digit_pulse_gen.sv | 109 ++++++++++
 tb/tb_digit_pulse_gen.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/edsac_timing_pkg.sv
// Shared digit-timing constants and controller state type for the EDSAC control section.
package edsac_timing_pkg;

    localparam int unsigned DIGITS_DEFAULT = 36;
    localparam int unsigned MINORS_DEFAULT = 16;

    localparam int unsigned D0  = 0;
    localparam int unsigned D1  = 1;
    localparam int unsigned D18 = 18;
    localparam int unsigned D35 = 35;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/digit_pulse_gen_if.sv
// Run/step controls and digit-timing outputs of digit_pulse_gen.
// dvec is present only when DIGIT_VECTOR_EN is defined.
interface digit_pulse_gen_if #(
    parameter int unsigned DIGITS = 36,
    parameter int unsigned MINORS = 16
);

    logic                        run;
    logic                        step;
    logic                        d0;
    logic                        d1;
    logic                        d18;
    logic                        d35;
    logic [5:0]                  digit;
    logic [$clog2(MINORS)-1:0]   minor;
    logic                        odd;
    logic                        major_start;
    logic                        running;
`ifdef DIGIT_VECTOR_EN
    logic [DIGITS-1:0]           dvec;
`endif

    // master is the pulse generator; slave is the controlling/consuming side
    modport master (
        input  run,
        input  step,
        output d0,
        output d1,
        output d18,
        output d35,
        output digit,
        output minor,
        output odd,
        output major_start,
`ifdef DIGIT_VECTOR_EN
        output dvec,
`endif
        output running
    );

    modport slave (
        output run,
        output step,
        input  d0,
        input  d1,
        input  d18,
        input  d35,
        input  digit,
        input  minor,
        input  odd,
        input  major_start,
`ifdef DIGIT_VECTOR_EN
        input  dvec,
`endif
        input  running
    );

endinterface

// File: rtl/mod_counter.sv
// Wrap-around counter 0..MODULUS-1 with enable; tc flags the last value.
module mod_counter #(
    parameter int unsigned WIDTH   = 6,
    parameter int unsigned MODULUS = 36
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    assign tc    = (count_q == LAST);
    assign count = count_q;

    always_comb begin
        count_d = count_q;
        if (en) begin
            count_d = tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/digit_pulse_gen.sv
// Master digit-timing source: nested digit/minor counters gated by a run/stop/step controller.
// Optional full one-hot digit vector under DIGIT_VECTOR_EN.
module digit_pulse_gen
    import edsac_timing_pkg::*;
#(
    parameter int unsigned DIGITS = DIGITS_DEFAULT,
    parameter int unsigned MINORS = MINORS_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    digit_pulse_gen_if.master bus
);

    localparam int unsigned MW = $clog2(MINORS);

    state_e          state_q;
    state_e          state_d;
    logic            running;
    logic            digit_tc;
    logic            minor_tc;
    logic [5:0]      digit;
    logic [MW-1:0]   minor;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: stopping is only honoured at the last digit of a minor cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d = RUN;
                end else if (bus.step) begin
                    state_d = DRAIN;
                end
            end
            RUN: begin
                if (!bus.run) begin
                    state_d = digit_tc ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (bus.run) begin
                    state_d = RUN;
                end else if (digit_tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign running = (state_q != IDLE);

    mod_counter #(
        .WIDTH   (6),
        .MODULUS (DIGITS)
    ) u_digit_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (running),
        .count (digit),
        .tc    (digit_tc)
    );

    mod_counter #(
        .WIDTH   (MW),
        .MODULUS (MINORS)
    ) u_minor_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (running & digit_tc),
        .count (minor),
        .tc    (minor_tc)
    );

    // Outputs decode registered state and counters only
    always_comb begin
        bus.running     = running;
        bus.digit       = digit;
        bus.minor       = minor;
        bus.odd         = minor[0];
        bus.d0          = running & (digit == 6'(D0));
        bus.d1          = running & (digit == 6'(D1));
        bus.d18         = running & (digit == 6'(D18));
        bus.d35         = running & (digit == 6'(D35));
        bus.major_start = running & (digit == 6'(D0)) & (minor == '0);
    end

`ifdef DIGIT_VECTOR_EN
    always_comb begin
        bus.dvec = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            bus.dvec[i] = running & (digit == 6'(i));
        end
    end
`endif

    logic unused_minor_tc;
    assign unused_minor_tc = minor_tc;

endmodule

// File: tb/tb_digit_pulse_gen.sv
// Directed self-checking bench for digit_pulse_gen; define DIGIT_VECTOR_EN to check dvec too.
module tb_digit_pulse_gen;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    digit_pulse_gen_if #(.DIGITS(36), .MINORS(16)) bus ();

    digit_pulse_gen #(
        .DIGITS (36),
        .MINORS (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [4:0] pulses();
        return {bus.d0, bus.d1, bus.d18, bus.d35, bus.major_start};
    endfunction

    int n_d0, n_d35, n_ms, n_busy, n_bad, n;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        bus.run  = 1'b0;
        bus.step = 1'b0;
        tick();
        check("reset_digit", bus.digit, 0);
        check("reset_minor", bus.minor, 0);
        check("reset_pulses_running", {pulses(), bus.running}, 0);
        rst = 1'b0;
        tick();
        check("idle_no_pulse", {pulses(), bus.running}, 0);

        // Free run: d0 one cycle after run sampled high, full major cycle
        bus.run = 1'b1;
        n_d0 = 0; n_ms = 0;
        for (int cyc = 1; cyc <= 577; cyc++) begin
            tick();
            if (cyc <= 576) n_d0 += int'(bus.d0);
            n_ms += int'(bus.major_start);
            if (cyc == 1) begin
                check("c1_d0", bus.d0, 1);
                check("c1_major_start", bus.major_start, 1);
                check("c1_odd", bus.odd, 0);
            end
            if (cyc == 2)  check("c2_d1", {bus.d0, bus.d1}, 2'b01);
            if (cyc == 19) check("c19_d18", bus.d18, 1);
            if (cyc == 36) check("c36_d35", {bus.d35, bus.digit}, {1'b1, 6'd35});
            if (cyc == 37) check("c37_d0_odd", {bus.d0, bus.odd, bus.major_start}, 3'b110);
            if (cyc == 577) check("c577_major_start", bus.major_start, 1);
        end
        check("major_d0_count", n_d0, 16);
        check("major_start_count", n_ms, 2);

        // Asynchronous reset mid-run at digit 20
        repeat (20) tick();
        check("pre_reset_digit", bus.digit, 20);
        rst = 1'b1;
        #1;
        check("async_reset_outs", {pulses(), bus.running, bus.digit, bus.minor}, 0);
        bus.run = 1'b0;
        tick();
        rst = 1'b0;
        n_bad = 0;
        repeat (50) begin
            tick();
            if (pulses() != 0 || bus.running || bus.digit != 0) n_bad++;
        end
        check("post_reset_quiet", n_bad, 0);

        // Drop run at digit 10 of minor 3
        bus.run = 1'b1;
        tick();
        repeat (118) tick();
        check("at_m3_d10", {bus.minor, bus.digit}, {4'd3, 6'd10});
        bus.run = 1'b0;
        repeat (25) tick();
        check("drain_d35", {bus.d35, bus.running}, 2'b11);
        tick();
        check("stop_idle", {bus.running, bus.minor, bus.odd, bus.digit}, {1'b0, 4'd4, 1'b0, 6'd0});
        n_bad = 0;
        repeat (10) begin
            tick();
            if (pulses() != 0) n_bad++;
        end
        check("stopped_quiet", n_bad, 0);

        // Single step from minor 4; second step mid-cycle ignored
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        n = 0; n_d0 = 0; n_d35 = 0;
        while (bus.running && n < 100) begin
            n_d0  += int'(bus.d0);
            n_d35 += int'(bus.d35);
            n++;
            bus.step = (n == 5);
            tick();
        end
        bus.step = 1'b0;
        check("step_len", n, 36);
        check("step_d0_d35", {n_d0[7:0], n_d35[7:0]}, 16'h0101);
        check("step_end", {bus.running, bus.minor, bus.odd}, {1'b0, 4'd5, 1'b1});
        tick();
        check("step_idle_hold", {bus.running, bus.minor}, {1'b0, 4'd5});

        // Drop at digit 5, re-raise at digit 30: no gap
        bus.run = 1'b1;
        tick();
        check("restart_d0", {bus.d0, bus.minor}, {1'b1, 4'd5});
        repeat (5) tick();
        bus.run = 1'b0;
        n_busy = 0;
        repeat (25) begin
            tick();
            n_busy += int'(bus.running);
        end
        check("drain_digit30", bus.digit, 30);
        bus.run = 1'b1;
        repeat (5) begin
            tick();
            n_busy += int'(bus.running);
        end
        check("rerun_d35", bus.d35, 1);
        tick();
        check("no_gap_d0", {bus.d0, bus.running, bus.minor}, {2'b11, 4'd6});
        check("busy_throughout", n_busy, 30);

`ifdef DIGIT_VECTOR_EN
        // Currently running at digit 0 of minor 6
        n_bad = 0;
        for (int i = 0; i < 36; i++) begin
            logic [35:0] one;
            one = 36'd1;
            if (bus.dvec !== (one << i) || bus.digit != 6'(i)) n_bad++;
            if (i < 35) tick();
        end
        check("dvec_onehot", n_bad, 0);
        bus.run = 1'b0;
        tick();
        check("dvec_idle", {bus.running, bus.dvec}, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
